// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg
//   Shared definitions for the shared-memory-bus arbiter: FSM state
//   encodings, owner codes and the round-robin owner selection helper.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  // Under contention the side that was not granted last wins; a single
  // pending request always wins.
  function automatic arb_owner_e pick_owner(input logic       inst_req,
                                            input logic       data_req,
                                            input arb_owner_e last_grant);
    arb_owner_e win;
    if (inst_req && data_req)
      win = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
    else if (data_req)
      win = OWN_DATA;
    else
      win = OWN_INST;
    return win;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Arbitrates instruction-fetch (IF) and data (DC/MEM) requests onto one
//   SRAM-like request / addr_ok / data_ok slave bus, one transaction at a
//   time, returns the response to the owning master and raises stall
//   requests while that master has work pending.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   inst_req/inst_addr             fetch request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok      fetch handshakes (combinational)
//   inst_rdata                     fetch read data (0 unless fetch owns DATA)
//   data_req/wr/sel/addr/wdata     load/store request (held until data_addr_ok)
//   data_addr_ok/data_data_ok      data handshakes (combinational)
//   data_rdata                     load data (0 unless data side owns DATA)
//   bus_req/wr/sel/addr/wdata      registered slave request fields
//   bus_addr_ok/bus_data_ok        slave handshakes
//   bus_rdata                      slave read data
//   stallreq_if/stallreq_mem       pipeline stall requests (combinational)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; a pending request is granted and latched
// ST_ADDR | bus_req high, fields stable, waiting for bus_addr_ok
// ST_DATA | address accepted, waiting for bus_data_ok
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_sel,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,

  output logic                stallreq_if,
  output logic                stallreq_mem
);

  arb_state_e state;
  arb_state_e state_next;
  // The owner of the current/most recent transaction is also the
  // last-granted side used for round-robin; both reset to INST.
  arb_owner_e owner;
  arb_owner_e grant_owner;
  logic       grant;

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_owner = pick_owner(inst_req, data_req, owner);
    case (state)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          grant      = 1'b1;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus_addr_ok)
          state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bus_data_ok)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_INST;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner   <= grant_owner;
        bus_req <= 1'b1;
        if (grant_owner == OWN_DATA) begin
          bus_wr    <= data_wr;
          bus_sel   <= data_sel;
          bus_addr  <= data_addr;
          bus_wdata <= data_wdata;
        end else begin
          bus_wr    <= 1'b0;
          bus_sel   <= '1;
          bus_addr  <= inst_addr;
          bus_wdata <= '0;
        end
      end else if (state == ST_ADDR && bus_addr_ok) begin
        bus_req <= 1'b0;
      end
    end
  end

  // Slave handshakes are qualified by state so stray pulses are ignored.
  assign inst_addr_ok = bus_addr_ok && (state == ST_ADDR) && (owner == OWN_INST);
  assign data_addr_ok = bus_addr_ok && (state == ST_ADDR) && (owner == OWN_DATA);
  assign inst_data_ok = bus_data_ok && (state == ST_DATA) && (owner == OWN_INST);
  assign data_data_ok = bus_data_ok && (state == ST_DATA) && (owner == OWN_DATA);

  assign inst_rdata = (state == ST_DATA && owner == OWN_INST) ? bus_rdata : '0;
  assign data_rdata = (state == ST_DATA && owner == OWN_DATA) ? bus_rdata : '0;

  // Stall is released in the response cycle so the stage can advance.
  assign stallreq_if  = (inst_req || (owner == OWN_INST && state != ST_IDLE))
                        && !inst_data_ok;
  assign stallreq_mem = (data_req || (owner == OWN_DATA && state != ST_IDLE))
                        && !data_data_ok;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_sel = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stallreq_if, stallreq_mem;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } op_t;

  int n_checks = 0;
  int n_errors = 0;

  // master-side stimulus
  op_t inst_q[$];
  op_t data_q[$];
  int  inst_gap, data_gap, gap_max;
  // slave-side controls
  int  force_a, force_d;
  bit  spur_en, force_bao, force_bdo;

  // transaction-level reference: a granted transaction at cycle n_g with
  // slave latencies a_l/d_l occupies the bus request over [n_g+1, n_g+1+a_l]
  // and is answered at n_g+2+a_l+d_l.
  int  cyc;
  bit  busy;
  bit  own;     // 0 = fetch, 1 = data
  bit  last;
  int  n_g, a_l, d_l;
  op_t cur;
  bit  grant_log[$];

  // observations pinned by literal expectations
  int          cap_iaok, cap_idok, cap_daok, cap_ddok, n_daok, breq_cnt;
  logic [31:0] cap_ird, cap_drd, cap_ird_at_ddok;
  logic        cap_sif[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_caps();
    cap_iaok = -1; cap_idok = -1; cap_daok = -1; cap_ddok = -1;
    n_daok = 0; breq_cnt = 0;
    cap_ird = '0; cap_drd = '0; cap_ird_at_ddok = '0;
    for (int i = 0; i < 8; i++) cap_sif[i] = 1'b0;
    grant_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_sel = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outputs",
        {20'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
         bus_req, bus_wr, stallreq_if, stallreq_mem, bus_sel},
        32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    cyc = 0; busy = 1'b0; last = 1'b0; own = 1'b0;
    inst_gap = 0; data_gap = 0;
    force_bao = 1'b0; force_bdo = 1'b0;
    clear_caps();
  endtask

  task automatic step();
    bit ireq, dreq, bao, bdo, in_addr, in_data, active;
    bit e_iaok, e_daok, e_idok, e_ddok, e_sif, e_smem;
    logic [31:0] brd;
    int aok_cyc, dok_cyc;
    @(posedge clk); #1;
    rst = 1'b0;
    ireq = (inst_gap == 0) && (inst_q.size() > 0);
    dreq = (data_gap == 0) && (data_q.size() > 0);
    inst_req  = ireq;
    inst_addr = ireq ? inst_q[0].addr : $urandom;
    data_req  = dreq;
    if (dreq) begin
      data_wr = data_q[0].wr; data_sel = data_q[0].sel;
      data_addr = data_q[0].addr; data_wdata = data_q[0].wdata;
    end else begin
      data_wr = 1'($urandom); data_sel = 4'($urandom);
      data_addr = $urandom; data_wdata = $urandom;
    end
    if (!busy && (ireq || dreq)) begin
      own  = (ireq && dreq) ? ~last : dreq;
      last = own;
      busy = 1'b1;
      n_g  = cyc;
      cur  = own ? data_q[0] : inst_q[0];
      a_l  = (force_a >= 0) ? force_a : int'($urandom_range(0, 3));
      d_l  = (force_d >= 0) ? force_d : int'($urandom_range(0, 3));
      grant_log.push_back(own);
    end
    aok_cyc = n_g + 1 + a_l;
    dok_cyc = n_g + 2 + a_l + d_l;
    in_addr = busy && (cyc >= n_g + 1) && (cyc <= aok_cyc);
    in_data = busy && (cyc >= n_g + 2 + a_l) && (cyc <= dok_cyc);
    bao = in_addr && (cyc == aok_cyc);
    bdo = in_data && (cyc == dok_cyc);
    if (!in_addr && (force_bao || (spur_en && $urandom_range(0, 3) == 0))) bao = 1'b1;
    if (!in_data && (force_bdo || (spur_en && $urandom_range(0, 3) == 0))) bdo = 1'b1;
    if (bdo && in_data) brd = cur.wr ? 32'd0 : cur.rdata;
    else if (bdo)       brd = $urandom;
    else                brd = 32'd0;
    bus_addr_ok = bao; bus_data_ok = bdo; bus_rdata = brd;

    e_iaok = bao && in_addr && !own;
    e_daok = bao && in_addr && own;
    e_idok = bdo && in_data && !own;
    e_ddok = bdo && in_data && own;
    active = busy && (cyc > n_g);
    e_sif  = (ireq || (active && !own)) && !e_idok;
    e_smem = (dreq || (active && own)) && !e_ddok;

    @(negedge clk);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_data_ok", inst_data_ok, e_idok);
    chk("data_data_ok", data_data_ok, e_ddok);
    chk("inst_rdata", inst_rdata, e_idok ? brd : 32'd0);
    chk("data_rdata", data_rdata, e_ddok ? brd : 32'd0);
    chk("bus_req", bus_req, in_addr);
    chk("stallreq_if", stallreq_if, e_sif);
    chk("stallreq_mem", stallreq_mem, e_smem);
    if (in_addr) begin
      chk("bus_wr", bus_wr, own ? cur.wr : 1'b0);
      chk("bus_sel", bus_sel, own ? cur.sel : 4'hF);
      chk("bus_addr", bus_addr, cur.addr);
      if (own && cur.wr) chk("bus_wdata", bus_wdata, cur.wdata);
    end

    if (inst_addr_ok) cap_iaok = cyc;
    if (data_addr_ok) begin cap_daok = cyc; n_daok++; end
    if (inst_data_ok) begin cap_idok = cyc; cap_ird = inst_rdata; end
    if (data_data_ok) begin cap_ddok = cyc; cap_drd = data_rdata; cap_ird_at_ddok = inst_rdata; end
    if (bus_req) breq_cnt++;
    if (cyc < 8) cap_sif[cyc] = stallreq_if;

    if (e_iaok) begin void'(inst_q.pop_front()); inst_gap = $urandom_range(0, gap_max); end
    else if (!ireq && inst_gap > 0) inst_gap--;
    if (e_daok) begin void'(data_q.pop_front()); data_gap = $urandom_range(0, gap_max); end
    else if (!dreq && data_gap > 0) data_gap--;
    if (busy && cyc == dok_cyc) busy = 1'b0;
    cyc++;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((inst_q.size() > 0 || data_q.size() > 0 || busy) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout cyc=%0d got=pending want=idle", cyc);
    end
    step();
  endtask

  function automatic op_t mk(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
    op_t o;
    o.wr = wr; o.sel = sel; o.addr = addr; o.wdata = wdata; o.rdata = rdata;
    return o;
  endfunction

  initial begin
    gap_max = 0; force_a = -1; force_d = -1; spur_en = 1'b0;

    // single fetch, zero-wait slave
    do_reset();
    force_a = 0; force_d = 0;
    inst_q.push_back(mk(1'b0, 4'hF, 32'hBFC00000, 32'd0, 32'h3C1D0000));
    drain(20);
    chk("s1_iaok_cyc", cap_iaok, 32'd1);
    chk("s1_idok_cyc", cap_idok, 32'd2);
    chk("s1_irdata", cap_ird, 32'h3C1D0000);
    chk("s1_stall", {29'd0, cap_sif[0], cap_sif[1], cap_sif[2]}, 32'b110);

    // simultaneous requests after reset: data first
    do_reset();
    inst_q.push_back(mk(1'b0, 4'hF, 32'hBFC00004, 32'd0, 32'h11112222));
    data_q.push_back(mk(1'b0, 4'hF, 32'h80000010, 32'd0, 32'hCAFEF00D));
    drain(20);
    chk("s2_ddok_cyc", cap_ddok, 32'd2);
    chk("s2_drdata", cap_drd, 32'hCAFEF00D);
    chk("s2_idok_cyc", cap_idok, 32'd5);
    chk("s2_order", {30'd0, grant_log[0], grant_log[1]}, 32'b10);

    // continuous contention: strict alternation D I D I D I
    do_reset();
    force_a = -1; force_d = -1;
    for (int i = 0; i < 3; i++) begin
      inst_q.push_back(mk(1'b0, 4'hF, 32'hBFC00100 + 4 * i, 32'd0, $urandom));
      data_q.push_back(mk(1'b0, 4'hF, 32'h80000100 + 4 * i, 32'd0, $urandom));
    end
    drain(100);
    chk("s3_ngrants", grant_log.size(), 32'd6);
    if (grant_log.size() == 6)
      chk("s3_order", {26'd0, grant_log[0], grant_log[1], grant_log[2],
                       grant_log[3], grant_log[4], grant_log[5]}, 32'b101010);

    // store with slave addr_ok delayed 3 cycles
    do_reset();
    force_a = 3; force_d = 1;
    data_q.push_back(mk(1'b1, 4'b0011, 32'h80000020, 32'h0000ABCD, 32'd0));
    drain(30);
    chk("s4_breq_cycles", breq_cnt, 32'd4);
    chk("s4_daok_cyc", cap_daok, 32'd4);
    chk("s4_ddok_cyc", cap_ddok, 32'd6);
    chk("s4_rdata_both", cap_drd | cap_ird_at_ddok, 32'd0);

    // reset while in DATA, then a late bus_data_ok
    do_reset();
    force_a = 0; force_d = 3;
    data_q.push_back(mk(1'b0, 4'hF, 32'h80000040, 32'd0, 32'h5A5A5A5A));
    repeat (3) step();
    chk("s5_in_data", {31'd0, bus_req}, 32'd0);
    do_reset();
    force_bdo = 1'b1;
    repeat (2) step();
    force_bdo = 1'b0;
    chk("s5_no_ddok", cap_ddok, 32'hFFFFFFFF);

    // stray bus_addr_ok during DATA and bus_data_ok in IDLE
    do_reset();
    force_a = 0; force_d = 2;
    force_bdo = 1'b1;
    step();
    force_bdo = 1'b0;
    force_bao = 1'b1;
    data_q.push_back(mk(1'b0, 4'hF, 32'h80000080, 32'd0, 32'h0BADBEEF));
    drain(20);
    force_bao = 1'b0;
    chk("s6_one_addr_ok", n_daok, 32'd1);
    chk("s6_drdata", cap_drd, 32'h0BADBEEF);

    // randomized traffic with stray slave pulses
    do_reset();
    force_a = -1; force_d = -1; gap_max = 3; spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      inst_q.push_back(mk(1'b0, 4'hF, {$urandom} & 32'hFFFFFFFC, 32'd0, $urandom));
      data_q.push_back(mk(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom));
    end
    drain(4000);
    chk("rnd_ngrants", grant_log.size(), 32'd80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
